// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency instruction memory and
// presents instr/nxt_pc to decode, with a skid register so a decode stall loses nothing.
module if_fetch #(
  parameter int unsigned          PC_W      = 16,
  parameter int unsigned          INSTR_W   = 17,
  parameter logic [PC_W-1:0]      RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 17'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_IM_ID,
  input  logic               flow_change_ID_EX,
  input  logic [PC_W-1:0]    dst_ID_EX,
  output logic [PC_W-1:0]    im_addr,
  output logic               im_re,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    nxt_pc_IM_ID
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic [PC_W-1:0]    rd_pc, rd_pc_nxt;
  logic               rd_vld, rd_vld_nxt;
  logic [INSTR_W-1:0] skid_instr, skid_instr_nxt;
  logic [PC_W-1:0]    skid_pc, skid_pc_nxt;
  logic [INSTR_W-1:0] live_instr;
  logic [PC_W-1:0]    live_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      rd_pc      <= '0;
      rd_vld     <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      rd_pc      <= rd_pc_nxt;
      rd_vld     <= rd_vld_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc    <= skid_pc_nxt;
    end
  end

  // What the memory is returning this cycle; a bubble when no read is in flight.
  always_comb begin
    live_instr = rd_vld ? im_rdata : NOP_INSTR;
    live_pc    = rd_vld ? rd_pc + PC_W'(1) : '0;
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    rd_pc_nxt      = rd_pc;
    rd_vld_nxt     = rd_vld;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;
    case (state)
      RUN: begin
        rd_pc_nxt  = pc;
        rd_vld_nxt = 1'b1;
        if (!stall_IM_ID) begin
          pc_nxt = pc + PC_W'(1);
        end else begin
          // pc holds so the IM re-reads it; mem[pc] is waiting when the stall ends
          skid_instr_nxt = live_instr;
          skid_pc_nxt    = live_pc;
          state_nxt      = HOLD;
        end
      end
      HOLD: begin
        if (!stall_IM_ID) begin
          pc_nxt    = pc + PC_W'(1);
          rd_pc_nxt = pc;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (flow_change_ID_EX) begin
      pc_nxt     = dst_ID_EX;
      rd_vld_nxt = 1'b0;
      state_nxt  = RUN;
    end
  end

  always_comb begin
    im_re = 1'b1;
    if (rst) begin
      im_addr      = RESET_PC;
      instr        = NOP_INSTR;
      nxt_pc_IM_ID = '0;
    end else begin
      im_addr      = pc;
      instr        = (state == HOLD) ? skid_instr : live_instr;
      nxt_pc_IM_ID = (state == HOLD) ? skid_pc : live_pc;
    end
  end

endmodule
